// File: rtl/tl_a_channel_buffer.sv
// ----------------------------------------------------------------------------
// tl_a_channel_buffer
//   Ready/valid FIFO for one TileLink A-channel bundle. Sits between a master
//   port and the crossbar/fragmenter to break timing paths and absorb bursts.
//
// Parameters
//   DEPTH    entries (1..16, any value, not only powers of two)
//   ADDR_W   address width
//   DATA_W   data width (multiple of 8); mask width is DATA_W/8
//   SIZE_W   lg2 transfer-size width
//   SOURCE_W source-ID width
//
// Ports
//   clock, reset          rising-edge clock, asynchronous active-high reset
//   in_valid / in_ready   upstream handshake; in_* payload
//   out_valid / out_ready downstream handshake; out_* payload = head entry
//   count                 current occupancy, 0..DEPTH
//
// Optional build macro
//   TL_A_CHANNEL_BUFFER_FLOW_EN : when empty, an incoming beat is presented
//   on out_* in the same cycle and bypasses storage if out_ready is high.
//   Undefined (default): no in->out combinational path, 1-cycle latency.
// ----------------------------------------------------------------------------
module tl_a_channel_buffer #(
    parameter int DEPTH    = 2,
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int SIZE_W   = 4,
    parameter int SOURCE_W = 3
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [2:0]                   in_opcode,
    input  logic [2:0]                   in_param,
    input  logic [SIZE_W-1:0]            in_size,
    input  logic [SOURCE_W-1:0]          in_source,
    input  logic [ADDR_W-1:0]            in_address,
    input  logic [DATA_W/8-1:0]          in_mask,
    input  logic [DATA_W-1:0]            in_data,
    input  logic                         in_corrupt,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [2:0]                   out_opcode,
    output logic [2:0]                   out_param,
    output logic [SIZE_W-1:0]            out_size,
    output logic [SOURCE_W-1:0]          out_source,
    output logic [ADDR_W-1:0]            out_address,
    output logic [DATA_W/8-1:0]          out_mask,
    output logic [DATA_W-1:0]            out_data,
    output logic                         out_corrupt,
    output logic [$clog2(DEPTH+1)-1:0]   count
);
    localparam int MASK_W = DATA_W / 8;
    localparam int CNT_W  = $clog2(DEPTH + 1);
    localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int PL_W   = 3 + 3 + SIZE_W + SOURCE_W + ADDR_W + MASK_W + DATA_W + 1;

    logic [PL_W-1:0]  r_mem [DEPTH];
    logic [PTR_W-1:0] r_head;
    logic [PTR_W-1:0] r_tail;
    logic [CNT_W-1:0] r_count;

    logic [PL_W-1:0]  w_in_pl;
    logic [PL_W-1:0]  w_out_pl;
    logic             w_empty;
    logic             w_enq;
    logic             w_deq;
    logic             w_pass;

    assign w_in_pl  = {in_opcode, in_param, in_size, in_source,
                       in_address, in_mask, in_data, in_corrupt};
    assign w_empty  = (r_count == '0);
    // Full blocks input even if the head leaves this cycle: keeps out_ready
    // off the in_ready path.
    assign in_ready = (r_count != CNT_W'(DEPTH));

`ifdef TL_A_CHANNEL_BUFFER_FLOW_EN
    logic w_flow;
    // Gated by reset so out_valid stays low while the buffer is held in reset.
    assign w_flow    = w_empty && in_valid && !reset;
    assign out_valid = !w_empty || w_flow;
    assign w_out_pl  = w_flow ? w_in_pl : r_mem[r_head];
    assign w_pass    = w_flow && out_ready;
`else
    assign out_valid = !w_empty;
    assign w_out_pl  = r_mem[r_head];
    assign w_pass    = 1'b0;
`endif

    // A bypassed beat is neither stored nor popped from storage.
    assign w_enq = in_valid && in_ready && !w_pass;
    assign w_deq = out_valid && out_ready && !w_empty;

    assign {out_opcode, out_param, out_size, out_source,
            out_address, out_mask, out_data, out_corrupt} = w_out_pl;
    assign count = r_count;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else begin
            if (w_enq) begin
                r_mem[r_tail] <= w_in_pl;
                r_tail <= (r_tail == PTR_W'(DEPTH - 1)) ? '0 : r_tail + PTR_W'(1);
            end
            if (w_deq)
                r_head <= (r_head == PTR_W'(DEPTH - 1)) ? '0 : r_head + PTR_W'(1);
            case ({w_enq, w_deq})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Upstream must hold a stalled beat unchanged until it is accepted.
    property p_in_hold;
        @(posedge clock) disable iff (reset)
            (in_valid && !in_ready) |=> (in_valid && $stable(w_in_pl));
    endproperty
    a_in_hold: assert property (p_in_hold);

    a_cnt_range: assert property (@(posedge clock) disable iff (reset)
                                  r_count <= CNT_W'(DEPTH));
endmodule

// File: tb/tb_tl_a_channel_buffer.sv
module tb_tl_a_channel_buffer;
    typedef struct packed {
        logic [2:0]  op;
        logic [2:0]  prm;
        logic [3:0]  sz;
        logic [2:0]  src;
        logic [31:0] addr;
        logic [3:0]  mask;
        logic [31:0] data;
        logic        cor;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid  [2];
    logic        in_ready  [2];
    logic        out_valid [2];
    logic        out_ready [2];
    beat_t       in_b      [2];
    beat_t       out_b     [2];
    logic [1:0]  count     [2];

    beat_t q0[$];
    beat_t q1[$];
    int    nvec = 0;
    int    nerr = 0;

    always #5 clk = ~clk;

    // Instance 0: DEPTH=2, instance 1: DEPTH=3 (non-power-of-two wrap).
    for (genvar g = 0; g < 2; g++) begin : g_dut
        tl_a_channel_buffer #(.DEPTH(2 + g)) u_dut (
            .clock(clk), .reset(rst),
            .in_valid(in_valid[g]), .in_ready(in_ready[g]),
            .in_opcode(in_b[g].op), .in_param(in_b[g].prm), .in_size(in_b[g].sz),
            .in_source(in_b[g].src), .in_address(in_b[g].addr), .in_mask(in_b[g].mask),
            .in_data(in_b[g].data), .in_corrupt(in_b[g].cor),
            .out_valid(out_valid[g]), .out_ready(out_ready[g]),
            .out_opcode(out_b[g].op), .out_param(out_b[g].prm), .out_size(out_b[g].sz),
            .out_source(out_b[g].src), .out_address(out_b[g].addr), .out_mask(out_b[g].mask),
            .out_data(out_b[g].data), .out_corrupt(out_b[g].cor),
            .count(count[g])
        );
    end

    function automatic beat_t mk(input logic [2:0] op, input logic [31:0] addr,
                                 input logic [3:0] mask, input logic [31:0] data,
                                 input logic [2:0] src);
        beat_t b;
        b.op = op; b.prm = 3'd0; b.sz = 4'd2; b.src = src;
        b.addr = addr; b.mask = mask; b.data = data; b.cor = 1'b0;
        return b;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input int d, input beat_t b);
        if (d == 0) q0.push_back(b);
        else        q1.push_back(b);
    endtask

    // Present a beat, hold it until accepted, drop valid just after the edge.
    task automatic send(input int d, input beat_t b);
        int n;
        push_exp(d, b);
        in_b[d]     = b;
        in_valid[d] = 1'b1;
        n = 0;
        @(negedge clk);
        while (!in_ready[d] && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            nvec++;
            nerr++;
            $display("FAIL send_timeout dut%0d: in_ready stayed 0, expected 1", d);
        end
        tick();
        in_valid[d] = 1'b0;
    endtask

    // Scoreboard monitor: every accepted output beat must match the oldest expectation.
    always @(negedge clk) begin
        if (!rst) begin
            for (int d = 0; d < 2; d++) begin
                if (out_valid[d] && out_ready[d]) begin
                    beat_t e;
                    nvec++;
                    if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
                        nerr++;
                        $display("FAIL beat_unexpected dut%0d: got %h, expected no beat", d, out_b[d]);
                    end else begin
                        e = (d == 0) ? q0.pop_front() : q1.pop_front();
                        if (out_b[d] !== e) begin
                            nerr++;
                            $display("FAIL beat dut%0d: got %h, expected %h", d, out_b[d], e);
                        end
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int d = 0; d < 2; d++) begin
            in_valid[d]  = 1'b0;
            out_ready[d] = 1'b0;
            in_b[d]      = '0;
        end

        // Reset with no clock edge yet
        #1;
        for (int d = 0; d < 2; d++) begin
            chk("rst_in_ready",  {31'd0, in_ready[d]},  32'd1);
            chk("rst_out_valid", {31'd0, out_valid[d]}, 32'd0);
            chk("rst_count",     {30'd0, count[d]},     32'd0);
            chk("rst_out_addr",  out_b[d].addr,         32'd0);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        tick();

        // Fill DEPTH=2 then drain
        send(0, mk(3'd0, 32'h1000, 4'hF, 32'h0000_0001, 3'd0));
        send(0, mk(3'd0, 32'h1004, 4'hF, 32'h0000_0002, 3'd1));
        @(negedge clk);
        chk("fill_count",    {30'd0, count[0]},    32'd2);
        chk("fill_in_ready", {31'd0, in_ready[0]}, 32'd0);
        chk("fill_head",     out_b[0].addr,        32'h1000);
        out_ready[0] = 1'b1;
        tick();
        tick();
        out_ready[0] = 1'b0;
        @(negedge clk);
        chk("drain_count", {30'd0, count[0]}, 32'd0);

        // Concurrent enqueue/dequeue at count=1
        tick();
        send(0, mk(3'd1, 32'h1100, 4'h3, 32'h1111_1111, 3'd2));
        out_ready[0] = 1'b1;
        send(0, mk(3'd1, 32'h1104, 4'hF, 32'hDEAD_BEEF, 3'd3));
        out_ready[0] = 1'b0;
        @(negedge clk);
        chk("conc_count", {30'd0, count[0]}, 32'd1);
        chk("conc_data",  out_b[0].data,     32'hDEAD_BEEF);
        tick();

        // At count=2, in_valid with out_ready: only the dequeue happens
        send(0, mk(3'd1, 32'h1108, 4'hF, 32'hB0B0_B0B0, 3'd4));
        begin
            beat_t c;
            c = mk(3'd1, 32'h110C, 4'hF, 32'hC0C0_C0C0, 3'd5);
            push_exp(0, c);
            in_b[0] = c;
            in_valid[0] = 1'b1;
            out_ready[0] = 1'b1;
        end
        @(negedge clk);
        chk("full_in_ready", {31'd0, in_ready[0]}, 32'd0);
        chk("full_count",    {30'd0, count[0]},    32'd2);
        tick();
        @(negedge clk);
        chk("full_deq_count", {30'd0, count[0]},    32'd1);
        chk("full_deq_ready", {31'd0, in_ready[0]}, 32'd1);
        tick();
        in_valid[0] = 1'b0;
        @(negedge clk);
        chk("conc2_count", {30'd0, count[0]}, 32'd1);
        tick();
        out_ready[0] = 1'b0;
        @(negedge clk);
        chk("conc_drain_count", {30'd0, count[0]}, 32'd0);

        // Wrap on DEPTH=3 with toggling out_ready
        tick();
        fork
            begin
                for (int i = 0; i < 7; i++)
                    send(1, mk(3'd0, 32'h100 + i * 4, 4'hF, 32'hA0 + i, i[2:0]));
            end
            begin
                for (int c = 0; c < 40; c++) begin
                    out_ready[1] = (c % 2 == 0);
                    @(negedge clk);
                    chk("wrap_count_le3", {31'd0, count[1] <= 2'd3}, 32'd1);
                    tick();
                end
            end
        join
        out_ready[1] = 1'b0;
        @(negedge clk);
        chk("wrap_drain_count", {30'd0, count[1]}, 32'd0);
        chk("wrap_all_seen",    q1.size(),         32'd0);

        // Reset in the middle of operation
        tick();
        send(0, mk(3'd0, 32'h2000, 4'hF, 32'h2, 3'd0));
        send(0, mk(3'd0, 32'h2004, 4'hF, 32'h3, 3'd1));
        @(negedge clk);
        chk("mid_count_pre", {30'd0, count[0]}, 32'd2);
        rst = 1'b1;
        #1;
        chk("mid_out_valid", {31'd0, out_valid[0]}, 32'd0);
        chk("mid_count",     {30'd0, count[0]},     32'd0);
        chk("mid_in_ready",  {31'd0, in_ready[0]},  32'd1);
        q0.delete();
        q1.delete();
        @(negedge clk);
        rst = 1'b0;
        tick();
        send(0, mk(3'd0, 32'h3000, 4'hF, 32'h4, 3'd2));
        @(negedge clk);
        chk("post_rst_valid", {31'd0, out_valid[0]}, 32'd1);
        chk("post_rst_addr",  out_b[0].addr,         32'h3000);
        out_ready[0] = 1'b1;
        tick();
        out_ready[0] = 1'b0;
        @(negedge clk);
        chk("post_rst_count", {30'd0, count[0]}, 32'd0);
        tick();

        // Empty buffer, beat offered with out_ready=1
        begin
            beat_t f;
            f = mk(3'd0, 32'h4000, 4'hF, 32'h5, 3'd3);
            push_exp(0, f);
            in_b[0] = f;
            in_valid[0] = 1'b1;
            out_ready[0] = 1'b1;
        end
        #1;
`ifdef TL_A_CHANNEL_BUFFER_FLOW_EN
        chk("flow_valid", {31'd0, out_valid[0]}, 32'd1);
        chk("flow_addr",  out_b[0].addr,         32'h4000);
        tick();
        in_valid[0] = 1'b0;
        @(negedge clk);
        chk("flow_count", {30'd0, count[0]}, 32'd0);
        tick();
        begin
            beat_t f2;
            f2 = mk(3'd0, 32'h4004, 4'hF, 32'h6, 3'd4);
            push_exp(0, f2);
            in_b[0] = f2;
            in_valid[0] = 1'b1;
            out_ready[0] = 1'b0;
        end
        #1;
        chk("flow_stall_valid", {31'd0, out_valid[0]}, 32'd1);
        chk("flow_stall_addr",  out_b[0].addr,         32'h4004);
        tick();
        in_valid[0] = 1'b0;
        @(negedge clk);
        chk("flow_stall_count", {30'd0, count[0]}, 32'd1);
        out_ready[0] = 1'b1;
        tick();
        out_ready[0] = 1'b0;
`else
        chk("lat_same_cycle_valid", {31'd0, out_valid[0]}, 32'd0);
        tick();
        in_valid[0] = 1'b0;
        @(negedge clk);
        chk("lat_next_valid", {31'd0, out_valid[0]}, 32'd1);
        chk("lat_next_addr",  out_b[0].addr,         32'h4000);
        tick();
        out_ready[0] = 1'b0;
`endif
        @(negedge clk);
        chk("end_count", {30'd0, count[0]}, 32'd0);
        chk("end_q0",    q0.size(),         32'd0);
        chk("end_q1",    q1.size(),         32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
